// File: rtl/split_merge_pkg.sv
// Shared definitions for channel split/merge stages: segment sizing,
// counter width and the two-segment FSM state type.
package split_merge_pkg;

  typedef enum logic {
    SEG1 = 1'b0,
    SEG2 = 1'b1
  } seg_state_e;

  // Pixels in one channel-group segment of a D x D feature map.
  function automatic int seg_len(input int d, input int c);
    return d * d * c;
  endfunction

  // Counter wide enough to hold any in-frame position, including the total.
  function automatic int cnt_width(input int t_1, input int t_2);
    return $clog2(t_1 + t_2 + 1);
  endfunction

endpackage

// File: rtl/split_2o_if.sv
// Pixel-stream bundle for split_2o: one concatenated input stream in,
// two branch streams plus frame status out.
interface split_2o_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic [DATA_WIDTH-1:0] pxl_out_1;
  logic                  valid_out_1;
  logic [DATA_WIDTH-1:0] pxl_out_2;
  logic                  valid_out_2;
  logic                  frame_done;
  logic                  busy;

  // Source side: drives the concatenated stream and observes the branches.
  modport master (
    output valid_in, pxl_in,
    input  pxl_out_1, valid_out_1, pxl_out_2, valid_out_2, frame_done, busy
  );

  // Splitter side.
  modport slave (
    input  valid_in, pxl_in,
    output pxl_out_1, valid_out_1, pxl_out_2, valid_out_2, frame_done, busy
  );
endinterface

// File: rtl/split_2o_seg_counter.sv
// Position counter within the current segment; the terminal count is an
// input so one counter can serve segments of different lengths.
module seg_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clear,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = inc && (count == term - CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/split_2o.sv
// Channel-split stage: routes the first D*D*C_1 pixels of each frame to
// branch 1 and the following D*D*C_2 pixels to branch 2, then rearms.
module split_2o
  import split_merge_pkg::*;
#(
  parameter int D          = 220,
  parameter int C_1        = 1,
  parameter int C_2        = 1,
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  split_2o_if.slave bus
);

  localparam int T_1 = seg_len(D, C_1);
  localparam int T_2 = seg_len(D, C_2);
  localparam int CW  = cnt_width(T_1, T_2);

  if (C_1 < 1) begin : g_bad_c1
    $error("split_2o: C_1 must be at least 1");
  end

  seg_state_e            state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         term;
  logic                  last;
  logic                  frame_end;
  logic                  take_1, take_2;

  logic [DATA_WIDTH-1:0] pxl_1_q, pxl_2_q;
  logic                  valid_1_q, valid_2_q, frame_done_q;

  assign take_1 = bus.valid_in && (state == SEG1);
  assign take_2 = bus.valid_in && (state == SEG2);

  // With no second segment, the end of SEG1 is also the end of the frame.
  assign frame_end = last && ((state == SEG2) || (T_2 == 0));

  always_comb begin
    term = (state == SEG1) ? CW'(T_1) : CW'(T_2);
  end

  seg_counter #(
    .CW (CW)
  ) u_seg_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.valid_in),
    .clear (last),
    .term  (term),
    .count (cnt),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEG1;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: defaults come first so every path assigns state_nxt and no latch
  // is inferred.
  always_comb begin
    state_nxt = state;
    if (last) begin
      if ((state == SEG1) && (T_2 != 0)) begin
        state_nxt = SEG2;
      end else begin
        state_nxt = SEG1;
      end
    end
  end

  // NOTE: the pixel holding registers are plain flops, so they are cleared on
  // reset like the rest of the outputs rather than left unknown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_1_q      <= '0;
      pxl_2_q      <= '0;
      valid_1_q    <= 1'b0;
      valid_2_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_1_q    <= take_1;
      valid_2_q    <= take_2;
      frame_done_q <= frame_end;
      if (take_1) begin
        pxl_1_q <= bus.pxl_in;
      end
      if (take_2) begin
        pxl_2_q <= bus.pxl_in;
      end
    end
  end

  assign bus.pxl_out_1   = pxl_1_q;
  assign bus.pxl_out_2   = pxl_2_q;
  assign bus.valid_out_1 = valid_1_q;
  assign bus.valid_out_2 = valid_2_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = (state == SEG2) || (cnt != '0);

endmodule

// File: tb/tb_split_2o.sv
// Bench for split_2o: two instances (C_2=2 and C_2=0) fed the same stream and
// compared every cycle against a frame-position reference model.
module tb_split_2o;

  localparam int DW = 32;

  logic clk;
  logic reset;

  split_2o_if #(.DATA_WIDTH(DW)) bus_a ();
  split_2o_if #(.DATA_WIDTH(DW)) bus_b ();

  split_2o #(.D(2), .C_1(1), .C_2(2), .DATA_WIDTH(DW)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  split_2o #(.D(2), .C_1(1), .C_2(0), .DATA_WIDTH(DW)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a frame is T_1 pixels for branch 1 then T_2 for branch 2.
  int          t1_m  [2];
  int          tot_m [2];
  int          pos   [2];
  logic        e_v1  [2];
  logic        e_v2  [2];
  logic        e_fd  [2];
  logic [31:0] e_p1  [2];
  logic [31:0] e_p2  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k]  = 0;
      e_v1[k] = 1'b0;
      e_v2[k] = 1'b0;
      e_fd[k] = 1'b0;
      e_p1[k] = '0;
      e_p2[k] = '0;
    end
  endtask

  task automatic model_edge(input logic v, input logic [31:0] p);
    for (int k = 0; k < 2; k++) begin
      e_fd[k] = 1'b0;
      if (v) begin
        if (pos[k] < t1_m[k]) begin
          e_v1[k] = 1'b1;
          e_v2[k] = 1'b0;
          e_p1[k] = p;
        end else begin
          e_v1[k] = 1'b0;
          e_v2[k] = 1'b1;
          e_p2[k] = p;
        end
        e_fd[k] = (pos[k] == tot_m[k] - 1);
        pos[k]  = (pos[k] + 1) % tot_m[k];
      end else begin
        e_v1[k] = 1'b0;
        e_v2[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    check("a_valid_out_1", 32'(bus_a.valid_out_1), 32'(e_v1[0]));
    check("a_pxl_out_1",   bus_a.pxl_out_1,        e_p1[0]);
    check("a_valid_out_2", 32'(bus_a.valid_out_2), 32'(e_v2[0]));
    check("a_pxl_out_2",   bus_a.pxl_out_2,        e_p2[0]);
    check("a_frame_done",  32'(bus_a.frame_done),  32'(e_fd[0]));
    check("a_busy",        32'(bus_a.busy),        32'(pos[0] != 0));
    check("a_valid_excl",  32'(bus_a.valid_out_1 & bus_a.valid_out_2), 32'(0));
    check("b_valid_out_1", 32'(bus_b.valid_out_1), 32'(e_v1[1]));
    check("b_pxl_out_1",   bus_b.pxl_out_1,        e_p1[1]);
    check("b_valid_out_2", 32'(bus_b.valid_out_2), 32'(e_v2[1]));
    check("b_pxl_out_2",   bus_b.pxl_out_2,        e_p2[1]);
    check("b_frame_done",  32'(bus_b.frame_done),  32'(e_fd[1]));
    check("b_busy",        32'(bus_b.busy),        32'(pos[1] != 0));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked at that point.
  task automatic cycle(input logic v, input logic [31:0] p);
    bus_a.valid_in = v;
    bus_a.pxl_in   = p;
    bus_b.valid_in = v;
    bus_b.pxl_in   = p;
    @(posedge clk);
    model_edge(v, p);
    #1;
    cyc++;
    check_all();
  endtask

  initial begin
    t1_m[0]  = 4;
    tot_m[0] = 12;
    t1_m[1]  = 4;
    tot_m[1] = 4;
    model_reset();

    reset          = 1'b1;
    bus_a.valid_in = 1'b0;
    bus_a.pxl_in   = '0;
    bus_b.valid_in = 1'b0;
    bus_b.pxl_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Continuous frame, pixels 0..11, then idle.
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'(i));
    repeat (3) cycle(1'b0, 32'hdead_beef);

    // Alternating valid across 24 cycles.
    for (int i = 0; i < 24; i++) cycle(~i[0], (i[0]) ? 32'hffff_ffff : 32'(100 + i / 2));
    repeat (2) cycle(1'b0, '0);

    // Two frames back-to-back.
    for (int i = 0; i < 24; i++) cycle(1'b1, 32'(i));
    cycle(1'b0, '0);

    // Six pixels (into SEG2 of instance a), then asynchronous reset mid-cycle.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(200 + i));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 32'(300 + i));

    // Random traffic with random gaps.
    for (int i = 0; i < 400; i++) cycle(($urandom_range(0, 3) != 0), $urandom);
    repeat (2) cycle(1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/split_2o.md
Name: split_2o

Overview:
- Channel-split stage, the inverse of the two-input channel merge.
- Accepts one valid-qualified pixel stream carrying a channel-concatenated feature map of D*D*C_1 pixels followed by D*D*C_2 pixels.
- Routes the first segment to output 1 and the second to output 2, then rearms for the next frame.
- Sits between a layer producing concatenated channels and two downstream branches that each consume a subset of channels.

Parameters:
- D, 220, spatial width/height of the feature map.
- C_1, 1, channel count routed to output 1.
- C_2, 1, channel count routed to output 2.
- DATA_WIDTH, 32, pixel width in bits.
- Derived localparams, not overridable:
  - T_1 = D*D*C_1.
  - T_2 = D*D*C_2.
  - CW = $clog2(T_1+T_2+1).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  pxl_in valid this cycle.
- pxl_in  input  DATA_WIDTH  concatenated input pixel.
- pxl_out_1  output  DATA_WIDTH  pixel for branch 1.
- valid_out_1  output  1  pxl_out_1 valid.
- pxl_out_2  output  DATA_WIDTH  pixel for branch 2.
- valid_out_2  output  1  pxl_out_2 valid.
- frame_done  output  1  one-cycle pulse with the last pixel of a frame.
- busy  output  1  high while a frame is partially received.

Behaviour:
- Reset (asynchronous, active-high), all outputs and state cleared:
  - pxl_out_1, pxl_out_2 = 0.
  - valid_out_1, valid_out_2, frame_done, busy = 0.
  - FSM = SEG1; counter cnt = 0.
- Reset asserted mid-frame discards the partial frame. The first valid_in after release is pixel 0 of a new frame.
- FSM states:
  - SEG1: valid_in routes to output 1.
  - SEG2: valid_in routes to output 2.
- cnt (CW bits) counts accepted pixels within the current segment. It advances only on cycles with valid_in=1; cycles with valid_in=0 hold all state.
- SEG1, valid_in=1:
  - pxl_out_1 <= pxl_in; valid_out_1 <= 1.
  - If cnt == T_1-1: cnt <= 0, go to SEG2. Otherwise cnt <= cnt+1.
- SEG2, valid_in=1:
  - pxl_out_2 <= pxl_in; valid_out_2 <= 1.
  - If cnt == T_2-1: cnt <= 0, frame_done <= 1, go to SEG1. Otherwise cnt <= cnt+1.
- Latency: exactly 1 cycle from valid_in to the matching valid_out_x. No internal buffering.
- Valid outputs:
  - valid_out_1 and valid_out_2 are registered and never high in the same cycle.
  - Each deasserts in the cycle after a valid_in=0 or after a switch to the other output.
- pxl_out_x holds its last value when its valid is low. Consumers must gate on valid.
- frame_done is registered and coincides with the valid_out_2 of pixel T_1+T_2-1.
- busy is combinational: high when FSM == SEG2 or cnt != 0.
- Back-to-back frames:
  - Pixel 0 of frame n+1 may arrive in the cycle right after the last pixel of frame n.
  - It goes to output 1 with no bubble.
  - valid_out_2 (last pixel) and valid_out_1 (first pixel) then appear on consecutive cycles.
- Degenerate C_2=0 (T_2=0): SEG2 is never entered. frame_done pulses with the last SEG1 pixel.
- C_1=0 is not supported. An elaboration-time check flags it.
- No backpressure: downstream branches must accept one pixel per cycle.

Decomposition:
- Shared package split_merge_pkg holds:
  - The segment-size function seg_len(D,C) = D*D*C.
  - The counter-width function.
  - The FSM state enum {SEG1, SEG2}.
- The package is reusable by merge and split blocks.
- One natural sub-module, seg_counter:
  - Parameters: width CW, terminal count.
  - Inputs: inc, clear.
  - Outputs: count, last (count == terminal-1 and inc).
  - split_2o instantiates it once and reloads the terminal count per state through a muxed terminal input.

Test Plan:
- D=2, C_1=1, C_2=2 (T_1=4, T_2=8); continuous valid_in with pxl_in = 0..11:
  - valid_out_1 high cycles 1-4 with values 0..3.
  - valid_out_2 high cycles 5-12 with values 4..11.
  - frame_done pulses cycle 12 only.
  - busy low after cycle 12.
- Same config, valid_in toggling 1,0,1,0 across 24 cycles:
  - Same 12-pixel routing.
  - Each valid_out pulse lags its valid_in by 1 cycle.
  - Counters hold during gaps.
- Two frames back-to-back (24 pixels, values 0..23):
  - Pixel 12 appears on pxl_out_1 in the cycle after frame_done.
  - Second frame_done comes with pixel 23.
  - No dropped or duplicated pixels.
- Reset asserted asynchronously after 6 pixels (mid-SEG2):
  - All outputs 0 immediately.
  - The next 12 pixels form a clean frame: first 4 on output 1.
- C_2=0, D=2, C_1=1; 8 pixels:
  - All on output 1.
  - frame_done pulses with pixels 3 and 7.
  - valid_out_2 never asserts.
- Default config (T_1=T_2=48400, CW=17); full frame:
  - cnt never exceeds 48399.
  - Exactly 48400 valid_out_1 and 48400 valid_out_2 pulses.
  - One frame_done.
